// File: rtl/tt_clk_pkg.sv
// Shared types and default loop constants for the frequency-lock controller.
package tt_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    MEAS   = 2'd2,
    UPDATE = 2'd3
  } state_e;

  localparam int TARGET_DEF  = 120;
  localparam int TOL_DEF     = 2;
  localparam int WIN_REF_DEF = 4;

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchroniser plus a third flop giving a one-cycle rising-edge pulse.
module tt_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hold,
  input  logic i_d,
  output logic o_rise
);

  logic [2:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else if (!i_hold) begin
      sync_q <= {sync_q[1:0], i_d};
    end
  end

  assign o_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tt_freq_lock_ctrl.sv
// Frequency-lock loop: counts i_clk_gen cycles over WIN_REF reference periods
// and nudges the tune code one step per window until the count is in band.
//
// state  | meaning
// IDLE   | loop disabled, counters and lock cleared, code held
// ARM    | waiting for a fresh reference edge to open a window
// MEAS   | counting generator cycles across WIN_REF reference periods
// UPDATE | one cycle: compare capture with target, step code, track streak
module tt_freq_lock_ctrl
  import tt_clk_pkg::*;
#(
  parameter int                 CODE_W   = 8,
  parameter logic [CODE_W-1:0]  CODE_RST = CODE_W'(128),
  parameter int                 COUNT_W  = 10,
  parameter int                 WIN_REF  = WIN_REF_DEF,
  parameter int                 TARGET   = TARGET_DEF,
  parameter int                 TOL      = TOL_DEF,
  parameter int                 LOCK_N   = 4
) (
  input  logic               i_clk_gen,
  input  logic               i_rst_n,
  input  logic               i_clk_ref,
  input  logic               i_enable,
  input  logic               i_scan_en,
  input  logic               i_scan_in,
  output logic [CODE_W-1:0]  o_dco_code,
  output logic               o_locked,
  output logic [COUNT_W-1:0] o_meas,
  output logic               o_scan_out
);

  localparam int RC_W = (WIN_REF > 1) ? $clog2(WIN_REF) : 1;
  localparam int ST_W = $clog2(LOCK_N + 1);

  localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
  localparam logic [COUNT_W-1:0] MEAS_LO    = COUNT_W'(TARGET - TOL);
  localparam logic [COUNT_W-1:0] MEAS_HI    = COUNT_W'(TARGET + TOL);
  localparam logic [RC_W-1:0]    REF_LAST   = RC_W'(WIN_REF - 1);
  localparam logic [ST_W-1:0]    STREAK_MAX = ST_W'(LOCK_N);
  localparam logic [CODE_W-1:0]  CODE_MAX   = '1;

  state_e             state_q;
  logic [CODE_W-1:0]  code_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] meas_q;
  logic [RC_W-1:0]    ref_cnt_q;
  logic [ST_W-1:0]    streak_q;
  logic               locked_q;
  logic               ref_rise;
  logic [COUNT_W-1:0] cnt_d;
  logic [ST_W-1:0]    streak_d;

  // Sync flops freeze along with everything else while scan is shifting.
  tt_sync_edge u_ref_edge (
    .i_clk   (i_clk_gen),
    .i_rst_n (i_rst_n),
    .i_hold  (i_scan_en),
    .i_d     (i_clk_ref),
    .o_rise  (ref_rise)
  );

  assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_W'(1);
  assign streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + ST_W'(1);

  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      code_q    <= CODE_RST;
      cnt_q     <= '0;
      meas_q    <= '0;
      ref_cnt_q <= '0;
      streak_q  <= '0;
      locked_q  <= 1'b0;
    end else if (i_scan_en) begin
      code_q <= {code_q[CODE_W-2:0], i_scan_in};
    end else if (!i_enable) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      streak_q  <= '0;
      locked_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          ref_cnt_q <= '0;
          streak_q  <= '0;
          locked_q  <= 1'b0;
          state_q   <= ARM;
        end
        ARM: begin
          if (ref_rise) begin
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            state_q   <= MEAS;
          end
        end
        MEAS: begin
          cnt_q <= cnt_d;
          if (ref_rise) begin
            if (ref_cnt_q == REF_LAST) begin
              meas_q  <= cnt_d;
              state_q <= UPDATE;
            end else begin
              ref_cnt_q <= ref_cnt_q + RC_W'(1);
            end
          end
        end
        UPDATE: begin
          state_q <= ARM;
          if (meas_q < MEAS_LO) begin
            if (code_q != CODE_MAX) code_q <= code_q + CODE_W'(1);
            streak_q <= '0;
            locked_q <= 1'b0;
          end else if (meas_q > MEAS_HI) begin
            if (code_q != '0) code_q <= code_q - CODE_W'(1);
            streak_q <= '0;
            locked_q <= 1'b0;
          end else begin
            streak_q <= streak_d;
            if (streak_d == STREAK_MAX) locked_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_dco_code = code_q;
  assign o_locked   = locked_q;
  assign o_meas     = meas_q;
  assign o_scan_out = code_q[CODE_W-1];

endmodule

// File: tb/tb_tt_freq_lock_ctrl.sv
// Scoreboard bench for tt_freq_lock_ctrl: random generator frequencies per
// segment, expected window results queued by a ratio-based reference model.
`timescale 1ns/1ps
module tb_tt_freq_lock_ctrl;
  import tt_clk_pkg::*;

  logic       clk_gen;
  logic       clk_ref;
  logic       i_rst_n;
  logic       i_enable;
  logic       i_scan_en;
  logic       i_scan_in;
  logic [7:0] o_dco_code;
  logic       o_locked;
  logic [9:0] o_meas;
  logic       o_scan_out;

  realtime half_gen = 2000.0 / 120.0;
  bit      ref_stuck = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int n;
    int code;
    int locked;
  } exp_t;
  exp_t exp_q[$];

  int m_code   = 128;
  int m_streak = 0;
  int m_locked = 0;

  tt_freq_lock_ctrl dut (
    .i_clk_gen  (clk_gen),
    .i_rst_n    (i_rst_n),
    .i_clk_ref  (clk_ref),
    .i_enable   (i_enable),
    .i_scan_en  (i_scan_en),
    .i_scan_in  (i_scan_in),
    .o_dco_code (o_dco_code),
    .o_locked   (o_locked),
    .o_meas     (o_meas),
    .o_scan_out (o_scan_out)
  );

  initial begin
    clk_gen = 1'b0;
    forever #(half_gen) clk_gen = ~clk_gen;
  end

  initial begin
    clk_ref = 1'b0;
    #137;
    forever begin
      #500;
      clk_ref = ref_stuck ? 1'b0 : ~clk_ref;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: one result per UPDATE cycle, checked on the following cycle.
  initial begin
    bit   pend = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk_gen);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window: got a window with no expectation (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (int'(o_meas) < e.n - 1 || int'(o_meas) > e.n + 1) begin
            failures++;
            $display("FAIL win_meas: got %0d expected %0d +/-1", o_meas, e.n);
          end
          chk("win_code", int'(o_dco_code), e.code);
          chk("win_locked", int'(o_locked), e.locked);
        end
      end
      pend = i_rst_n && (dut.state_q == UPDATE);
    end
  end

  // Reference model: classify the ideal count against the band, step code.
  function automatic void model_window(input int n);
    if (n < 118) begin
      if (m_code < 255) m_code++;
      m_streak = 0;
      m_locked = 0;
    end else if (n > 122) begin
      if (m_code > 0) m_code--;
      m_streak = 0;
      m_locked = 0;
    end else begin
      if (m_streak < 4) m_streak++;
      m_locked = (m_streak >= 4) ? 1 : 0;
    end
  endfunction

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_gen);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending windows expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_seg(input int n, input int w);
    exp_t e;
    half_gen = 2000.0 / real'(n);
    repeat (4) @(negedge clk_gen);
    i_enable = 1'b1;
    for (int k = 0; k < w; k++) begin
      model_window(n);
      e.n = n;
      e.code = m_code;
      e.locked = m_locked;
      exp_q.push_back(e);
    end
    wait_drain(w * 200 + 400);
  endtask

  task automatic drop_enable();
    @(negedge clk_gen);
    i_enable = 1'b0;
    @(negedge clk_gen);
    chk("drop_locked", int'(o_locked), 0);
    chk("drop_code", int'(o_dco_code), m_code);
    m_streak = 0;
    m_locked = 0;
  endtask

  task automatic scan_load(input logic [7:0] v);
    logic [7:0] old;
    old = 8'(m_code);
    @(negedge clk_gen);
    i_scan_en = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      chk("scan_out_bit", int'(o_scan_out), int'(old[i]));
      i_scan_in = v[i];
      @(negedge clk_gen);
    end
    i_scan_en = 1'b0;
    i_scan_in = 1'b0;
    chk("scan_code", int'(o_dco_code), int'(v));
    m_code = int'(v);
  endtask

  initial begin
    int cls, n, w, k;
    i_rst_n   = 1'b0;
    i_enable  = 1'b0;
    i_scan_en = 1'b0;
    i_scan_in = 1'b0;
    #100;
    chk("rst_code", int'(o_dco_code), 128);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_meas", int'(o_meas), 0);
    chk("rst_scan_out", int'(o_scan_out), 1);
    @(negedge clk_gen);
    i_rst_n = 1'b1;

    // Nominal 30 MHz: in band every window, lock on the fourth.
    run_seg(120, 5);

    // One-cycle enable drop while locked, then a full relock.
    drop_enable();
    i_enable = 1'b1;
    run_seg(120, 4);

    // Random frequency segments.
    for (int s = 0; s < 5; s++) begin
      cls = int'($urandom_range(0, 2));
      case (cls)
        0:       n = int'($urandom_range(100, 116));
        1:       n = int'($urandom_range(124, 140));
        default: n = int'($urandom_range(119, 121));
      endcase
      w = int'($urandom_range(2, 5));
      drop_enable();
      run_seg(n, w);
    end

    // Saturation at both ends of the code range.
    drop_enable();
    scan_load(8'hFF);
    run_seg(110, 3);
    drop_enable();
    scan_load(8'h00);
    run_seg(135, 3);
    drop_enable();
    scan_load(8'hA5);

    // Reference stuck low: FSM parks in ARM, code untouched.
    ref_stuck = 1'b1;
    repeat (40) @(negedge clk_gen);
    i_enable = 1'b1;
    repeat (1500) @(negedge clk_gen);
    chk("stuck_state", int'(dut.state_q), int'(ARM));
    chk("stuck_code", int'(o_dco_code), m_code);
    drop_enable();
    ref_stuck = 1'b0;

    // Async reset in the middle of a measurement window.
    run_seg(120, 1);
    k = 0;
    while (dut.state_q != MEAS && k < 600) begin
      @(negedge clk_gen);
      k++;
    end
    chk("reach_meas", int'(dut.state_q), int'(MEAS));
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("async_code", int'(o_dco_code), 128);
    chk("async_locked", int'(o_locked), 0);
    chk("async_meas", int'(o_meas), 0);
    i_enable = 1'b0;
    m_code = 128;
    m_streak = 0;
    m_locked = 0;
    @(negedge clk_gen);
    i_rst_n = 1'b1;
    run_seg(120, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
